rr_collect_8to1: RTL and testbench

- Sequential 8-to-1 collector: merges eight independent val/rdy input channels into one val/rdy output stream.
- Fairness comes from a round-robin arbiter; each forwarded message is tagged with its source index.
- Inverse of the 1-to-8 steering block: the two blocks sit back-to-back in fan-out/fan-in fabrics, with out_sel feeding the steering block's sel.
- One-entry registered output stage gives 1-cycle latency and full throughput.

---
 rtl/rr_collect_pkg.sv | 10 +
 rtl/rr_arb_8.sv | 30 +++
 rtl/rr_collect_8to1.sv | 68 ++++++
 tb/tb_rr_collect_8to1.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_collect_pkg.sv
// Shared types and sizes for the 8-to-1 round-robin collector.
package rr_collect_pkg;

    localparam int NCHAN = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCHAN-1:0] grant_t;

endpackage

// File: rtl/rr_arb_8.sv
// Combinational round-robin priority search over eight requesters.
module rr_arb_8
    import rr_collect_pkg::*;
(
    input  grant_t req,
    input  sel_t   ptr,
    output grant_t grant,
    output sel_t   gidx,
    output logic   any
);

    sel_t w_idx;

    // Search ptr, ptr+1, ... with 3-bit wrap; first hit wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NCHAN; k++) begin
            w_idx = ptr + SEL_W'(k);
            if (!any && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                gidx         = w_idx;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_collect_8to1.sv
// Eight val/rdy channels merged into one tagged stream via
// a round-robin arbiter and a one-entry registered output stage.
module rr_collect_8to1
    import rr_collect_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCHAN-1:0]       in_val,
    output logic [NCHAN-1:0]       in_rdy,
    input  logic [NCHAN*nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [nbits-1:0]       out_msg,
    output logic [SEL_W-1:0]       out_sel
);

    sel_t             r_ptr;
    logic             r_out_val;
    logic [nbits-1:0] r_out_msg;
    sel_t             r_out_sel;

    grant_t           w_grant;
    sel_t             w_gidx;
    logic             w_any;
    logic             w_can_accept;
    logic             w_in_xfer;
    logic [nbits-1:0] w_msgs [NCHAN];

    for (genvar c = 0; c < NCHAN; c++) begin : g_unpack
        assign w_msgs[c] = in_msg[c*nbits +: nbits];
    end

    rr_arb_8 u_arb (
        .req   (in_val),
        .ptr   (r_ptr),
        .grant (w_grant),
        .gidx  (w_gidx),
        .any   (w_any)
    );

    // Draining the register this cycle frees it for a new message.
    assign w_can_accept = !r_out_val || out_rdy;
    assign w_in_xfer    = w_any && w_can_accept;
    assign in_rdy       = w_grant & {NCHAN{w_can_accept}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_out_val <= 1'b0;
            r_out_msg <= '0;
            r_out_sel <= '0;
        end else if (w_in_xfer) begin
            r_out_msg <= w_msgs[w_gidx];
            r_out_sel <= w_gidx;
            r_out_val <= 1'b1;
            r_ptr     <= w_gidx + SEL_W'(1);
        end else if (out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign out_val = r_out_val;
    assign out_msg = r_out_msg;
    assign out_sel = r_out_sel;

endmodule

// File: tb/tb_rr_collect_8to1.sv
// Self-checking bench: directed table, hand sequences, random vs model.
module tb_rr_collect_8to1;

    logic        clk;
    logic        reset;
    logic [7:0]  in_val;
    logic [7:0]  in_rdy;
    logic [63:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_msg;
    logic [2:0]  out_sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msgs [8];

    // Reference state, kept as plain integers.
    int         m_ptr;
    logic       m_val;
    logic [7:0] m_msg;
    int         m_sel;

    rr_collect_8to1 #(.nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_sel (out_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] v;
        logic       r;
        logic [7:0] e_rdy;
        logic       e_val;
        logic [2:0] e_sel;
        logic [7:0] e_msg;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pack_msgs();
        for (int c = 0; c < 8; c++) in_msg[c*8 +: 8] = msgs[c];
    endtask

    task automatic default_msgs();
        for (int c = 0; c < 8; c++) msgs[c] = 8'h10 + 8'(c);
        pack_msgs();
    endtask

    task automatic do_reset();
        in_val  = '0;
        out_rdy = 1'b1;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        reset = 1'b0;
        m_ptr = 0;
        m_val = 1'b0;
        m_msg = '0;
        m_sel = 0;
    endtask

    function automatic int mgrant(input logic [7:0] v, input int p);
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // One model-checked cycle: starts and ends 1 time unit after posedge.
    task automatic mstep(input logic [7:0] v, input logic r);
        int         g;
        logic [7:0] e_rdy;
        in_val  = v;
        out_rdy = r;
        pack_msgs();
        #2;
        g     = mgrant(v, m_ptr);
        e_rdy = (g >= 0 && (!m_val || r)) ? 8'(1 << g) : 8'h00;
        chk("rnd_in_rdy", 64'(in_rdy), 64'(e_rdy));
        chk("rnd_out_val", 64'(out_val), 64'(m_val));
        if (m_val) begin
            chk("rnd_out_msg", 64'(out_msg), 64'(m_msg));
            chk("rnd_out_sel", 64'(out_sel), 64'(m_sel));
        end
        @(posedge clk);
        if (e_rdy != 0) begin
            m_msg = msgs[g];
            m_sel = g;
            m_val = 1'b1;
            m_ptr = (g + 1) % 8;
        end else if (r) begin
            m_val = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = '0;
        out_rdy = 1'b0;
        default_msgs();

        tbl[0]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
        tbl[2]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10};
        tbl[3]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10};
        tbl[4]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11};
        tbl[5]  = '{8'h05, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12};
        tbl[6]  = '{8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
        tbl[7]  = '{8'h05, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12};
        tbl[8]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 8'h12};
        tbl[9]  = '{8'h80, 1'b0, 8'h80, 1'b1, 3'd7, 8'h17};
        tbl[10] = '{8'h01, 1'b0, 8'h00, 1'b1, 3'd7, 8'h17};
        tbl[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 8'h17};
        tbl[12] = '{8'h60, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15};
        tbl[13] = '{8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
        tbl[14] = '{8'h05, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12};

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_val  = '0;
            out_rdy = 1'b1;
            #2;
            chk("idle_in_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
            chk("idle_out_val", 64'(out_val), 64'd0);
            chk("idle_out_sel", 64'(out_sel), 64'd0);
        end

        // Directed table.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            in_val  = tbl[i].v;
            out_rdy = tbl[i].r;
            #2;
            chk($sformatf("tbl%0d_in_rdy", i), 64'(in_rdy), 64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_val", i), 64'(out_val), 64'(tbl[i].e_val));
            chk($sformatf("tbl%0d_out_sel", i), 64'(out_sel), 64'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_out_msg", i), 64'(out_msg), 64'(tbl[i].e_msg));
        end

        // Single channel with a distinct payload.
        do_reset();
        msgs[4] = 8'hA5;
        pack_msgs();
        in_val  = 8'b0001_0000;
        out_rdy = 1'b1;
        #2;
        chk("single_in_rdy", 64'(in_rdy), 64'h10);
        @(posedge clk);
        #1;
        chk("single_out_val", 64'(out_val), 64'd1);
        chk("single_out_msg", 64'(out_msg), 64'hA5);
        chk("single_out_sel", 64'(out_sel), 64'd4);
        in_val = 8'b0011_0001;
        #2;
        chk("single_ptr5", 64'(in_rdy), 64'h20);
        @(posedge clk);
        #1;
        default_msgs();

        // Round-robin fairness under full throughput.
        do_reset();
        in_val  = 8'hFF;
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_val", i), 64'(out_val), 64'd1);
            chk($sformatf("rr%0d_sel", i), 64'(out_sel), 64'(i % 8));
            chk($sformatf("rr%0d_msg", i), 64'(out_msg), 64'(8'h10 + 8'(i % 8)));
        end

        // Asynchronous reset while stalled.
        do_reset();
        in_val  = 8'h01;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_pre_val", 64'(out_val), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_val", 64'(out_val), 64'd0);
        chk("arst_sel", 64'(out_sel), 64'd0);
        chk("arst_msg", 64'(out_msg), 64'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        in_val  = 8'h80;
        out_rdy = 1'b1;
        #2;
        chk("arst_in_rdy", 64'(in_rdy), 64'h80);
        @(posedge clk);
        #1;
        chk("arst_post_sel", 64'(out_sel), 64'd7);
        chk("arst_post_msg", 64'(out_msg), 64'h17);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] v;
            logic       r;
            for (int c = 0; c < 8; c++) msgs[c] = 8'($urandom);
            v = 8'($urandom) & 8'($urandom);
            r = ($urandom_range(0, 3) != 0);
            mstep(v, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
